fifo_mem_prog: RTL and testbench

Parametrised synchronous FIFO: the next generation of fifo_mem. It supports any integer depth, not only powers of two, and a selectable read mode (registered or first-word-fall-through). It adds run-time programmable almost-full and almost-empty levels, an occupancy count output, a synchronous flush, and sticky error flags. It sits between producer and consumer blocks in a single clock domain.

---
 rtl/fifo_mem_prog.sv | 140 ++++++++++++++
 tb/tb_fifo_mem_prog.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fifo_mem_prog.sv
// Synchronous FIFO for any depth >= 2, with registered or first-word-fall-through
// read, programmable almost-full/almost-empty levels, occupancy count, flush and sticky errors.
module fifo_mem_prog #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 18,
  parameter int READ_MODE  = 0,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_in,
  input  logic                  areset_b,
  input  logic                  flush,
  input  logic                  trans_write,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  trans_read,
  input  logic [CNT_W-1:0]      af_level,
  input  logic [CNT_W-1:0]      ae_level,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_W-1:0]      count,
  output logic                  full_ind,
  output logic                  empty_ind,
  output logic                  almost_full_ind,
  output logic                  almost_empty_ind,
  output logic                  overflow_ind,
  output logic                  underflow_ind
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_ok_s, rd_ok_s, wr_rej_s, rd_rej_s;
  logic                  full_s, empty_s;

  assign empty_s = (count_q == {CNT_W{1'b0}});
  assign full_s  = (count_q == CNT_W'(DEPTH));

  // Accept/reject strobes; flush swallows both requests without raising errors.
  always_comb begin
    rd_ok_s  = trans_read & ~empty_s & ~flush;
    wr_ok_s  = trans_write & (~full_s | trans_read) & ~flush;
    rd_rej_s = trans_read & ~rd_ok_s & ~flush;
    wr_rej_s = trans_write & ~wr_ok_s & ~flush;
  end

  // Next-state for pointers, occupancy, registered read data and sticky flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
      rdata_d  = {DATA_WIDTH{1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_ok_s) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
        rdata_d  = mem_q[rd_ptr_q];
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    // A rejection in the same cycle as err_clr keeps the flag set.
    if (wr_rej_s) begin
      ovf_d = 1'b1;
    end else if (err_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (rd_rej_s) begin
      udf_d = 1'b1;
    end else if (err_clr) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      rdata_q  <= {DATA_WIDTH{1'b0}};
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array is intentionally left unreset.
  always_ff @(posedge clk_in) begin
    if (wr_ok_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // FWFT exposes the head directly; an empty FIFO presents zero.
  always_comb begin
    if (READ_MODE == 1) begin
      data_out = empty_s ? {DATA_WIDTH{1'b0}} : mem_q[rd_ptr_q];
    end else begin
      data_out = rdata_q;
    end
  end

  assign count            = count_q;
  assign full_ind         = full_s;
  assign empty_ind        = empty_s;
  assign almost_full_ind  = (count_q >= af_level);
  assign almost_empty_ind = (count_q <= ae_level);
  assign overflow_ind     = ovf_q;
  assign underflow_ind    = udf_q;

endmodule

// File: tb/tb_fifo_mem_prog.sv
// Directed bench for fifo_mem_prog: a registered-read and an FWFT instance share stimulus.
module tb_fifo_mem_prog;

  logic        clk_in = 1'b0;
  logic        areset_b, flush, trans_write, trans_read, err_clr;
  logic [15:0] data_in;
  logic [4:0]  af_level, ae_level;
  logic [15:0] dout0, dout1;
  logic [4:0]  count0, count1;
  logic        full0, empty0, af0, ae0, ovf0, udf0;
  logic        full1, empty1, af1, ae1, ovf1, udf1;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk_in = ~clk_in;

  fifo_mem_prog #(.DATA_WIDTH(16), .DEPTH(18), .READ_MODE(0)) u_reg (
    .clk_in(clk_in), .areset_b(areset_b), .flush(flush), .trans_write(trans_write),
    .data_in(data_in), .trans_read(trans_read), .af_level(af_level), .ae_level(ae_level),
    .err_clr(err_clr), .data_out(dout0), .count(count0), .full_ind(full0), .empty_ind(empty0),
    .almost_full_ind(af0), .almost_empty_ind(ae0), .overflow_ind(ovf0), .underflow_ind(udf0));

  fifo_mem_prog #(.DATA_WIDTH(16), .DEPTH(18), .READ_MODE(1)) u_fwft (
    .clk_in(clk_in), .areset_b(areset_b), .flush(flush), .trans_write(trans_write),
    .data_in(data_in), .trans_read(trans_read), .af_level(af_level), .ae_level(ae_level),
    .err_clr(err_clr), .data_out(dout1), .count(count1), .full_ind(full1), .empty_ind(empty1),
    .almost_full_ind(af1), .almost_empty_ind(ae1), .overflow_ind(ovf1), .underflow_ind(udf1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock with the given requests, then return inputs to idle; sample #1 after the edge.
  task automatic step(input logic w, input logic r, input logic [15:0] d);
    trans_write = w;
    trans_read  = r;
    data_in     = d;
    @(posedge clk_in);
    #1;
    trans_write = 1'b0;
    trans_read  = 1'b0;
    err_clr     = 1'b0;
    flush       = 1'b0;
  endtask

  initial begin
    areset_b = 1'b0; flush = 1'b0; trans_write = 1'b0; trans_read = 1'b0;
    err_clr = 1'b0; data_in = 16'h0; af_level = 5'd18; ae_level = 5'd3;
    #12;
    check("rst_count", 32'(count0), 32'd0);
    check("rst_empty", 32'(empty0), 32'd1);
    check("rst_full", 32'(full0), 32'd0);
    check("rst_ae", 32'(ae0), 32'd1);
    check("rst_af", 32'(af0), 32'd0);
    check("rst_ovf", 32'(ovf0), 32'd0);
    check("rst_dout", 32'(dout0), 32'd0);
    areset_b = 1'b1;
    @(negedge clk_in);

    for (int i = 1; i <= 18; i++) step(1'b1, 1'b0, 16'(i));
    check("fill_count", 32'(count0), 32'd18);
    check("fill_full", 32'(full0), 32'd1);
    check("fill_af", 32'(af0), 32'd1);
    check("fill_ovf", 32'(ovf0), 32'd0);
    check("fwft_head", 32'(dout1), 32'd1);

    step(1'b1, 1'b0, 16'd19);
    check("ovf_set", 32'(ovf0), 32'd1);
    check("ovf_count", 32'(count0), 32'd18);
    step(1'b0, 1'b0, 16'd0);
    check("ovf_sticky", 32'(ovf0), 32'd1);
    err_clr = 1'b1;
    step(1'b0, 1'b0, 16'd0);
    check("ovf_clr", 32'(ovf0), 32'd0);

    for (int i = 1; i <= 18; i++) begin
      check("drain_fwft", 32'(dout1), 32'(i));
      step(1'b0, 1'b1, 16'd0);
      check("drain_reg", 32'(dout0), 32'(i));
    end
    check("drain_empty", 32'(empty0), 32'd1);
    step(1'b0, 1'b1, 16'd0);
    check("udf_set", 32'(udf0), 32'd1);
    check("udf_hold", 32'(dout0), 32'd18);
    check("udf_count", 32'(count0), 32'd0);
    err_clr = 1'b1;
    step(1'b0, 1'b0, 16'd0);
    check("udf_clr", 32'(udf0), 32'd0);

    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 16'(16'h100 + b * 5 + k));
      for (int k = 0; k < 5; k++) begin
        step(1'b0, 1'b1, 16'd0);
        check("wrap_data", 32'(dout0), 32'(16'h100 + b * 5 + k));
      end
    end
    check("wrap_empty", 32'(empty0), 32'd1);

    for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 16'(16'h200 + i));
    step(1'b1, 1'b1, 16'h2FF);
    check("rw_full_count", 32'(count0), 32'd18);
    check("rw_full_ovf", 32'(ovf0), 32'd0);
    check("rw_full_data", 32'(dout0), 32'h200);
    for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 16'd0);
    check("rw_last", 32'(dout0), 32'h2FF);
    step(1'b1, 1'b1, 16'h300);
    check("rw_empty_count", 32'(count0), 32'd1);
    check("rw_empty_udf", 32'(udf0), 32'd1);
    check("rw_empty_fwft", 32'(dout1), 32'h300);
    err_clr = 1'b1;
    step(1'b0, 1'b1, 16'd0);
    check("rw_empty_data", 32'(dout0), 32'h300);
    check("rw_udf_clr", 32'(udf0), 32'd0);

    af_level = 5'd12; ae_level = 5'd3;
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 16'(i));
    check("af_11", 32'(af0), 32'd0);
    step(1'b1, 1'b0, 16'd11);
    check("af_12", 32'(af0), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'd0);
    check("ae_4", 32'(ae0), 32'd0);
    step(1'b0, 1'b1, 16'd0);
    check("ae_3", 32'(ae0), 32'd1);
    check("ae_count", 32'(count0), 32'd3);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'(i));
    check("af_lvl12_c11", 32'(af0), 32'd0);
    af_level = 5'd10;
    #1;
    check("af_lvl10_c11", 32'(af0), 32'd1);
    af_level = 5'd31; ae_level = 5'd20;
    #1;
    check("af_above_depth", 32'(af0), 32'd0);
    check("ae_above_depth", 32'(ae0), 32'd1);
    af_level = 5'd12; ae_level = 5'd3;

    flush = 1'b1;
    step(1'b0, 1'b0, 16'd0);
    check("flush_count", 32'(count1), 32'd0);
    step(1'b1, 1'b0, 16'hAAAA);
    check("fwft_visible", 32'(dout1), 32'hAAAA);
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 16'(i));
    step(1'b1, 1'b0, 16'hBEEF);
    check("pre_flush_ovf", 32'(ovf1), 32'd1);
    flush = 1'b1;
    step(1'b1, 1'b1, 16'h1234);
    check("flushw_count", 32'(count1), 32'd0);
    check("flushw_fwft", 32'(dout1), 32'd0);
    check("flushw_reg", 32'(dout0), 32'd0);
    check("flushw_ovf", 32'(ovf1), 32'd1);
    check("flushw_udf", 32'(udf1), 32'd0);

    step(1'b1, 1'b0, 16'h55);
    check("pre_rst_count", 32'(count0), 32'd1);
    areset_b = 1'b0;
    #1;
    check("midrst_count", 32'(count0), 32'd0);
    check("midrst_ovf", 32'(ovf1), 32'd0);
    check("midrst_empty", 32'(empty1), 32'd1);
    areset_b = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
